sram_responder: RTL
===================

// Module: sram_responder
// PURPOSE
//  Synthesizable memory-side responder for the TOP memory bus (Address/ReadEnable/WriteEnable/DataIN/DataOut).
//  Replaces the behavioural SRAM model: 32x16 storage, 1-cycle registered read, plus post-reset clear and a host preload port.
//  Sits between the processing TOP (initiator) and the board/test host; adds read/write counters and a sticky error flag.
// PARAMETERS
//  DATA_WIDTH      16  word width
//  ADDR_WIDTH      5   address width; DEPTH = 2**ADDR_WIDTH (32)
//  CLEAR_ON_RESET  1   1: zero every word after reset; 0: skip clear, contents preserved
// PORTS
//  Clock        in   1   single clock, all state on posedge
//  Reset        in   1   synchronous, active-low
//  Address      in   5   initiator address
//  ReadEnable   in   1   initiator read request
//  WriteEnable  in   1   initiator write request
//  DataIN       in   16  initiator write data
//  DataOut      out  16  read data, registered
//  DataValid    out  1   high the cycle after an accepted read
//  InitDone     out  1   high once clear finished; bus/host accesses honoured only when high
//  HostLoad     in   1   host preload strobe
//  HostAddress  in   5   host preload address
//  HostData     in   16  host preload data
//  ReadCount    out  8   accepted reads, saturating
//  WriteCount   out  8   accepted writes (bus only), saturating
//  AccessError  out  1   sticky protocol-violation flag
// BEHAVIOUR
//  Reset (Reset=0 at posedge): state<=CLEAR, ClearPtr<=0, DataOut<=0, DataValid<=0, InitDone<=0,
//   ReadCount<=0, WriteCount<=0, AccessError<=0. Memory array itself not reset.
//  FSM CLEAR: each posedge writes 0 to mem[ClearPtr], ClearPtr++; after writing DEPTH-1 -> SERVE, InitDone<=1.
//   InitDone rises on the 32nd posedge with Reset=1. CLEAR_ON_RESET=0: CLEAR lasts 1 cycle, no writes.
//  In CLEAR: HostLoad ignored; ReadEnable or WriteEnable high -> ignored, AccessError<=1, DataValid stays 0.
//  FSM SERVE, priority per cycle: HostLoad > ReadEnable > WriteEnable.
//   HostLoad: mem[HostAddress]<=HostData; any simultaneous RE/WE dropped and AccessError<=1.
//   ReadEnable: DataOut<=mem[Address] (value before any write this cycle); DataValid<=1 next cycle only.
//   WriteEnable (RE low): mem[Address]<=DataIN; DataOut unchanged.
//   RE and WE both high: read performed, write dropped, AccessError<=1.
//  DataOut holds last read value when no read; DataValid is a 1-cycle pulse per read (back-to-back reads -> held high).
//  Read latency 1 cycle; write visible to a read issued the following cycle (read-after-write, no bypass needed).
//  Counters increment on accepted read/write, saturate at 255 (no wrap). Host loads not counted.
//  Address wrap: ADDR_WIDTH bits cover DEPTH exactly; no out-of-range case.
//  AccessError clears only on reset. Reset mid-SERVE restarts CLEAR; reset mid-CLEAR restarts ClearPtr at 0.
//  SERVE is terminal; only reset leaves it.
// TESTING
//  1 Reset low 2 cycles, release -> InitDone=0 for 31 posedges, =1 after 32nd; reads of addr 0,7,31 return 0000.
//  2 SERVE: HostLoad addr7=1234, next cycle RE addr7 -> DataOut=1234 and DataValid=1 one cycle later; ReadCount=1.
//  3 WE addr31 DataIN=BEEF cycle n, RE addr31 cycle n+1 -> DataOut=BEEF after n+2 edge; WriteCount=1, AccessError=0.
//  4 mem[15]=00AA; RE+WE addr15 DataIN=5555 -> DataOut=00AA, later read still 00AA, AccessError=1.
//  5 RE during CLEAR -> DataValid=0, AccessError=1; then reset mid-SERVE -> counters 0, InitDone 0, DataOut 0, clear reruns.
//  6 300 consecutive reads -> DataValid held high, ReadCount stops at 255.

Source files
------------

// File: rtl/sram_responder.sv
// sram_responder: 32x16 memory-side responder with post-reset clear, host preload port,
// saturating access counters and a sticky protocol-error flag.
module sram_responder #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_WIDTH     = 5,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] Address,
    input  logic                  ReadEnable,
    input  logic                  WriteEnable,
    input  logic [DATA_WIDTH-1:0] DataIN,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  DataValid,
    output logic                  InitDone,
    input  logic                  HostLoad,
    input  logic [ADDR_WIDTH-1:0] HostAddress,
    input  logic [DATA_WIDTH-1:0] HostData,
    output logic [7:0]            ReadCount,
    output logic [7:0]            WriteCount,
    output logic                  AccessError
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, SERVE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] clear_ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_data;

    // Single write port: clear sweep in CLEAR, otherwise host preload beats a plain bus write
    always_comb begin
        mem_we   = Reset && (state == CLEAR ? CLEAR_ON_RESET : (HostLoad || (WriteEnable && !ReadEnable)));
        mem_addr = state == CLEAR ? clear_ptr : (HostLoad ? HostAddress : Address);
        mem_data = state == CLEAR ? '0 : (HostLoad ? HostData : DataIN);
    end

    // Storage is never reset; only the clear sweep zeroes it
    always_ff @(posedge Clock) begin
        if (mem_we) mem[mem_addr] <= mem_data;
    end

    // Control FSM with registered read data, valid pulse, counters and sticky error
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state       <= CLEAR;
            clear_ptr   <= '0;
            DataOut     <= '0;
            DataValid   <= 1'b0;
            InitDone    <= 1'b0;
            ReadCount   <= '0;
            WriteCount  <= '0;
            AccessError <= 1'b0;
        end else if (state == CLEAR) begin
            DataValid <= 1'b0;
            clear_ptr <= clear_ptr + 1'b1;
            if (ReadEnable || WriteEnable) AccessError <= 1'b1;
            if (!CLEAR_ON_RESET || clear_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                state    <= SERVE;
                InitDone <= 1'b1;
            end
        end else begin
            DataValid <= 1'b0;
            if (HostLoad) begin
                if (ReadEnable || WriteEnable) AccessError <= 1'b1;
            end else if (ReadEnable) begin
                DataOut   <= mem[Address];
                DataValid <= 1'b1;
                ReadCount <= ReadCount + 8'(ReadCount != 8'hFF);
                if (WriteEnable) AccessError <= 1'b1;
            end else if (WriteEnable) begin
                WriteCount <= WriteCount + 8'(WriteCount != 8'hFF);
            end
        end
    end
endmodule
